// File: rtl/boss_controller_if.sv
// boss_controller_if: VGA pixel query, sprite ROM read and keyed pixel output bus of boss_controller
interface boss_controller_if #(parameter int AW = 10);
    logic [9:0] x;
    logic [8:0] y;
    logic [AW-1:0] rom_addr;
    logic [23:0] rom_q;
    logic boss_pix;
    logic [7:0] boss_r, boss_g, boss_b;
    modport master(input x, y, rom_q, output rom_addr, boss_pix, boss_r, boss_g, boss_b);
    modport slave(output x, y, rom_q, input rom_addr, boss_pix, boss_r, boss_g, boss_b);
endinterface

// File: rtl/boss_controller.sv
// boss_controller: boss life-cycle FSM, bounded 4-mode motion and keyed sprite pixel path; BOSS_HIT_TINT_EN tints INVULN pixels
module boss_controller #(
    parameter int W = 32,
    parameter int H = 32,
    parameter int HP_MAX = 3,
    parameter int X_INIT = 150,
    parameter int Y_INIT = 100,
    parameter int X_MIN = 100,
    parameter int X_MAX = 500,
    parameter int Y_MIN = 50,
    parameter int Y_MAX = 150,
    parameter int STEP = 1,
    parameter int INVULN_FRAMES = 8,
    parameter int DEATH_FRAMES = 16,
    parameter logic [23:0] KEY = 24'hFFFFFF
) (
    input  logic clk,
    input  logic reset,
    boss_controller_if.master bus,
    input  logic frame_tick,
    input  logic boss_active,
    input  logic bullet_hit,
    input  logic [1:0] mode,
    output logic [9:0] boss_x,
    output logic [8:0] boss_y,
    output logic [$clog2(HP_MAX+1)-1:0] hp,
    output logic boss_hit,
    output logic boss_dead
);
    localparam int AW = $clog2(W * H);
    localparam int HW = $clog2(HP_MAX + 1);
    localparam int TW = $clog2((INVULN_FRAMES > DEATH_FRAMES ? INVULN_FRAMES : DEATH_FRAMES) + 1);
    typedef enum logic [2:0] {IDLE, ALIVE, INVULN, DYING, DEAD} state_t;
    state_t state, state_n;
    logic [HW-1:0] hp_n;
    logic [TW-1:0] timer, timer_n;
    logic [9:0] x_n;
    logic [8:0] y_n;
    logic dir_x, dir_y, dir_x_n, dir_y_n, dead_n;
    logic blink, bullet_hit_q, in_box, in_box_q, visible, pix;
    logic hit_edge, accept, tick_on, moving, x_act, y_act;
    logic [11:0] bx, by, x_fwd, x_bck, y_fwd, y_bck;
    logic x_over, x_under, y_over, y_under;
    logic [23:0] colour;
    assign hit_edge = bullet_hit & ~bullet_hit_q;
    assign accept = hit_edge & boss_active & (state == ALIVE);
    assign tick_on = frame_tick & boss_active;
    assign moving = tick_on & (state == ALIVE || state == INVULN);
    assign y_act = moving & ~mode[0];
    assign x_act = moving & (mode[0] ^ mode[1]);
    assign bx = 12'(boss_x);
    assign by = 12'(boss_y);
    assign x_fwd = bx + 12'(STEP);
    assign x_bck = bx - 12'(STEP);
    assign y_fwd = by + 12'(STEP);
    assign y_bck = by - 12'(STEP);
    // Underflow is avoided by testing the current position against MIN+STEP
    assign x_over = x_fwd > 12'(X_MAX);
    assign x_under = bx < 12'(X_MIN + STEP);
    assign y_over = y_fwd > 12'(Y_MAX);
    assign y_under = by < 12'(Y_MIN + STEP);
    always_comb begin
        state_n = state;
        hp_n = hp;
        timer_n = timer;
        dead_n = boss_dead;
        x_n = x_act ? 10'(dir_x ? (x_over ? 12'(X_MAX) : x_fwd) : (x_under ? 12'(X_MIN) : x_bck)) : boss_x;
        y_n = y_act ? 9'(dir_y ? (y_over ? 12'(Y_MAX) : y_fwd) : (y_under ? 12'(Y_MIN) : y_bck)) : boss_y;
        dir_x_n = x_act ? (dir_x ? ~x_over : x_under) : dir_x;
        dir_y_n = y_act ? (dir_y ? ~y_over : y_under) : dir_y;
        case (state)
            IDLE: state_n = boss_active ? ALIVE : IDLE;
            ALIVE: if (accept) begin
                hp_n = hp - 1'b1;
                state_n = (hp == HW'(1)) ? DYING : INVULN;
                timer_n = (hp == HW'(1)) ? TW'(DEATH_FRAMES) : TW'(INVULN_FRAMES);
            end
            INVULN: if (tick_on) begin
                timer_n = timer - 1'b1;
                state_n = (timer == TW'(1)) ? ALIVE : INVULN;
            end
            DYING: if (tick_on) begin
                timer_n = timer - 1'b1;
                state_n = (timer == TW'(1)) ? DEAD : DYING;
                dead_n = timer == TW'(1);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hp <= HW'(HP_MAX);
            timer <= '0;
            boss_x <= 10'(X_INIT);
            boss_y <= 9'(Y_INIT);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
            blink <= 1'b0;
            bullet_hit_q <= 1'b0;
            boss_hit <= 1'b0;
            boss_dead <= 1'b0;
            in_box_q <= 1'b0;
        end else begin
            state <= state_n;
            hp <= hp_n;
            timer <= timer_n;
            boss_x <= x_n;
            boss_y <= y_n;
            dir_x <= dir_x_n;
            dir_y <= dir_y_n;
            blink <= blink ^ frame_tick;
            bullet_hit_q <= bullet_hit;
            boss_hit <= accept;
            boss_dead <= dead_n;
            in_box_q <= in_box;
        end
    end
    assign in_box = ({2'b0, bus.x} >= bx) && ({2'b0, bus.x} < bx + 12'(W)) &&
                    ({3'b0, bus.y} >= by) && ({3'b0, bus.y} < by + 12'(H));
    assign bus.rom_addr = (AW'(bus.y) - AW'(boss_y)) * AW'(W) + AW'(bus.x) - AW'(boss_x);
    // DYING blinks: the sprite shows only on even frame parity
    assign visible = boss_active & (state == ALIVE || state == INVULN || (state == DYING && !blink));
    assign pix = in_box_q & visible & (bus.rom_q != KEY);
`ifdef BOSS_HIT_TINT_EN
    assign colour = !pix ? 24'h000000 : (state == INVULN && blink) ? 24'hFF2020 : bus.rom_q;
`else
    assign colour = pix ? bus.rom_q : 24'h000000;
`endif
    assign bus.boss_pix = pix;
    assign {bus.boss_r, bus.boss_g, bus.boss_b} = colour;
endmodule

// File: tb/tb_boss_controller.sv
// tb_boss_controller: scoreboard bench for boss_controller motion, hit life cycle, pause and sprite pixel path
module tb_boss_controller;
    logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, boss_active = 1'b0, bullet_hit = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] boss_x;
    logic [8:0] boss_y;
    logic [1:0] hp;
    logic boss_hit, boss_dead;
    logic [23:0] colour;
    int errors = 0, checks = 0, ticks = 0, rom_sel = 0;
    typedef struct {int px; int py; logic pix; logic [23:0] col;} exp_t;
    exp_t sb[$];
    int pos_q[$];

    boss_controller_if #(.AW(10)) bus();
    boss_controller dut(.clk(clk), .reset(reset), .bus(bus), .frame_tick(frame_tick),
                        .boss_active(boss_active), .bullet_hit(bullet_hit), .mode(mode),
                        .boss_x(boss_x), .boss_y(boss_y), .hp(hp), .boss_hit(boss_hit),
                        .boss_dead(boss_dead));
    assign colour = {bus.boss_r, bus.boss_g, bus.boss_b};
    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [9:0] a);
        if (rom_sel == 0) return 24'hFFFFFF;
        if (rom_sel == 1) return 24'h123456;
        return (a % 7 == 3) ? 24'hFFFFFF : {a[7:0] ^ 8'h5A, 6'd0, a[9:8], 8'hC3};
    endfunction
    always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);

    task automatic do_reset();
        reset = 1'b1; boss_active = 1'b0; bullet_hit = 1'b0; frame_tick = 1'b0; mode = 2'd0;
        bus.x = 10'd0; bus.y = 9'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0; ticks = 0;
        @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ticks++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; boss_active = 1'b1; bullet_hit = 1'b0; frame_tick = 1'b0;
        bus.x = 10'd160; bus.y = 9'd110; rom_sel = 1;
        repeat (2) @(negedge clk);
        checks++; if (boss_x !== 10'd150) begin errors++; $display("FAIL reset_x got %0d want 150", boss_x); end
        checks++; if (boss_y !== 9'd100) begin errors++; $display("FAIL reset_y got %0d want 100", boss_y); end
        checks++; if (hp !== 2'd3) begin errors++; $display("FAIL reset_hp got %0d want 3", hp); end
        checks++; if (boss_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", boss_hit); end
        checks++; if (boss_dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %b want 0", boss_dead); end
        checks++; if (bus.boss_pix !== 1'b0) begin errors++; $display("FAIL reset_pix got %b want 0", bus.boss_pix); end
        checks++; if (colour !== 24'h0) begin errors++; $display("FAIL reset_colour got %h want 000000", colour); end
        do_reset();
        bus.x = 10'd160; bus.y = 9'd110; bullet_hit = 1'b1;
        @(negedge clk);
        checks++; if (boss_hit !== 1'b0) begin errors++; $display("FAIL idle_hit got %b want 0", boss_hit); end
        checks++; if (bus.boss_pix !== 1'b0) begin errors++; $display("FAIL idle_pix got %b want 0", bus.boss_pix); end
        bullet_hit = 1'b0;
    endtask

    task automatic test_pixel_path();
        int cx[$], cy[$];
        exp_t e, o;
        logic [23:0] d;
        logic inb;
        do_reset();
        boss_active = 1'b1; mode = 2'd3;
        @(negedge clk);
        for (int i = 140; i <= 190; i++) begin cx.push_back(i); cy.push_back(100); end
        for (int i = 170; i <= 185; i++) begin cx.push_back(i); cy.push_back(131); end
        for (int i = 170; i <= 175; i++) begin cx.push_back(i); cy.push_back(132); end
        for (int i = 150; i <= 155; i++) begin cx.push_back(i); cy.push_back(99); end
        for (int s = 2; s >= 0; s--) begin
            rom_sel = s;
            for (int i = 0; i <= cx.size(); i++) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.boss_pix !== e.pix) begin errors++; $display("FAIL pix_path (%0d,%0d) rom%0d got %b want %b", e.px, e.py, s, bus.boss_pix, e.pix); end
                    checks++;
                    if (colour !== e.col) begin errors++; $display("FAIL colour_path (%0d,%0d) rom%0d got %h want %h", e.px, e.py, s, colour, e.col); end
                end
                if (i < cx.size()) begin
                    bus.x = 10'(cx[i]); bus.y = 9'(cy[i]);
                    inb = cx[i] >= 150 && cx[i] < 182 && cy[i] >= 100 && cy[i] < 132;
                    d = rom_fn(10'((cy[i] - 100) * 32 + cx[i] - 150));
                    o.px = cx[i]; o.py = cy[i];
                    o.pix = inb && d != 24'hFFFFFF;
                    o.col = o.pix ? d : 24'h0;
                    sb.push_back(o);
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_vertical();
        int e;
        do_reset();
        boss_active = 1'b1; mode = 2'd0;
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            pos_q.push_back(k <= 50 ? 100 + k : (k == 51 ? 150 : 150 - (k - 51)));
            tick();
            e = pos_q.pop_front();
            checks++; if (boss_y !== 9'(e)) begin errors++; $display("FAIL vert_y tick %0d got %0d want %0d", k, boss_y, e); end
            checks++; if (boss_x !== 10'd150) begin errors++; $display("FAIL vert_x tick %0d got %0d want 150", k, boss_x); end
        end
    endtask

    task automatic test_diag_pause();
        do_reset();
        boss_active = 1'b1; mode = 2'd2; rom_sel = 1;
        @(negedge clk);
        repeat (10) tick();
        checks++; if (boss_x !== 10'd160 || boss_y !== 9'd110) begin errors++; $display("FAIL diag_pos got (%0d,%0d) want (160,110)", boss_x, boss_y); end
        mode = 2'd3;
        repeat (5) tick();
        checks++; if (boss_x !== 10'd160 || boss_y !== 9'd110) begin errors++; $display("FAIL hold_pos got (%0d,%0d) want (160,110)", boss_x, boss_y); end
        boss_active = 1'b0; mode = 2'd2; bus.x = 10'd165; bus.y = 9'd115;
        repeat (5) tick();
        checks++; if (boss_x !== 10'd160 || boss_y !== 9'd110) begin errors++; $display("FAIL pause_pos got (%0d,%0d) want (160,110)", boss_x, boss_y); end
        checks++; if (bus.boss_pix !== 1'b0) begin errors++; $display("FAIL pause_pix got %b want 0", bus.boss_pix); end
        boss_active = 1'b1;
        tick();
        checks++; if (boss_x !== 10'd161 || boss_y !== 9'd111) begin errors++; $display("FAIL resume_pos got (%0d,%0d) want (161,111)", boss_x, boss_y); end
        checks++; if (bus.boss_pix !== 1'b1 || colour !== 24'h123456) begin errors++; $display("FAIL resume_pix got %b/%h want 1/123456", bus.boss_pix, colour); end
    endtask

    task automatic test_hits();
        int n;
        logic [23:0] want;
        do_reset();
        boss_active = 1'b1; mode = 2'd3; rom_sel = 1; bus.x = 10'd160; bus.y = 9'd110;
        @(negedge clk);
        bullet_hit = 1'b1;
        @(negedge clk);
        checks++; if (boss_hit !== 1'b1 || hp !== 2'd2) begin errors++; $display("FAIL hit1 got hit=%b hp=%0d want 1/2", boss_hit, hp); end
        bullet_hit = 1'b0;
        @(negedge clk);
        checks++; if (boss_hit !== 1'b0) begin errors++; $display("FAIL hit1_pulse got %b want 0", boss_hit); end
        repeat (3) tick();
        bullet_hit = 1'b1;
        @(negedge clk);
        checks++; if (boss_hit !== 1'b0) begin errors++; $display("FAIL invuln_ignore got hit=%b want 0", boss_hit); end
        bullet_hit = 1'b0;
        @(negedge clk);
        checks++; if (hp !== 2'd2) begin errors++; $display("FAIL invuln_hp got %0d want 2", hp); end
        for (int p = 0; p < 2; p++) begin
`ifdef BOSS_HIT_TINT_EN
            want = (ticks % 2 == 1) ? 24'hFF2020 : 24'h123456;
`else
            want = 24'h123456;
`endif
            checks++; if (bus.boss_pix !== 1'b1 || colour !== want) begin errors++; $display("FAIL invuln_colour parity %0d got %b/%h want 1/%h", ticks % 2, bus.boss_pix, colour, want); end
            tick();
        end
        repeat (2) tick();
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        @(negedge clk);
        checks++; if (hp !== 2'd2) begin errors++; $display("FAIL invuln7_hp got %0d want 2", hp); end
        tick();
        bullet_hit = 1'b1; n = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); n += int'(boss_hit); end
        bullet_hit = 1'b0;
        checks++; if (n != 1) begin errors++; $display("FAIL held_pulses got %0d want 1", n); end
        checks++; if (hp !== 2'd1) begin errors++; $display("FAIL held_hp got %0d want 1", hp); end
        repeat (8) tick();
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        checks++; if (boss_hit !== 1'b1 || hp !== 2'd0) begin errors++; $display("FAIL fatal_hit got hit=%b hp=%0d want 1/0", boss_hit, hp); end
        for (int p = 0; p < 2; p++) begin
            checks++; if (bus.boss_pix !== (ticks % 2 == 0)) begin errors++; $display("FAIL dying_blink parity %0d got %b want %b", ticks % 2, bus.boss_pix, ticks % 2 == 0); end
            tick();
        end
        repeat (13) tick();
        checks++; if (boss_dead !== 1'b0) begin errors++; $display("FAIL dying15_dead got %b want 0", boss_dead); end
        tick();
        checks++; if (boss_dead !== 1'b1) begin errors++; $display("FAIL dead_flag got %b want 1", boss_dead); end
        for (int p = 0; p < 4; p++) begin
            tick();
            checks++; if (bus.boss_pix !== 1'b0 || boss_dead !== 1'b1) begin errors++; $display("FAIL dead_pix got pix=%b dead=%b want 0/1", bus.boss_pix, boss_dead); end
        end
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        checks++; if (boss_hit !== 1'b0 || hp !== 2'd0) begin errors++; $display("FAIL dead_hit got hit=%b hp=%0d want 0/0", boss_hit, hp); end
    endtask

    task automatic test_pause_timer();
        do_reset();
        boss_active = 1'b1; mode = 2'd3;
        @(negedge clk);
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        repeat (4) tick();
        boss_active = 1'b0;
        repeat (10) tick();
        boss_active = 1'b1;
        repeat (3) tick();
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        @(negedge clk);
        checks++; if (hp !== 2'd2) begin errors++; $display("FAIL paused_timer_hp got %0d want 2", hp); end
        tick();
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        checks++; if (boss_hit !== 1'b1 || hp !== 2'd1) begin errors++; $display("FAIL resumed_hit got hit=%b hp=%0d want 1/1", boss_hit, hp); end
        repeat (8) tick();
        boss_active = 1'b0;
        bullet_hit = 1'b1;
        @(negedge clk);
        bullet_hit = 1'b0;
        checks++; if (boss_hit !== 1'b0 || hp !== 2'd1) begin errors++; $display("FAIL paused_hit got hit=%b hp=%0d want 0/1", boss_hit, hp); end
    endtask

    task automatic test_reset_dying();
        do_reset();
        boss_active = 1'b1; mode = 2'd2;
        @(negedge clk);
        repeat (5) tick();
        mode = 2'd3;
        for (int h = 0; h < 3; h++) begin
            bullet_hit = 1'b1;
            @(negedge clk);
            bullet_hit = 1'b0;
            if (h < 2) repeat (8) tick();
        end
        repeat (2) tick();
        checks++; if (hp !== 2'd0 || boss_x !== 10'd155 || boss_y !== 9'd105) begin errors++; $display("FAIL predying got hp=%0d (%0d,%0d) want 0 (155,105)", hp, boss_x, boss_y); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (hp !== 2'd3 || boss_x !== 10'd150 || boss_y !== 9'd100) begin errors++; $display("FAIL async_reset got hp=%0d (%0d,%0d) want 3 (150,100)", hp, boss_x, boss_y); end
        checks++; if (boss_dead !== 1'b0 || bus.boss_pix !== 1'b0) begin errors++; $display("FAIL async_reset_flags got dead=%b pix=%b want 0/0", boss_dead, bus.boss_pix); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.x = 10'd0; bus.y = 9'd0;
        test_reset();
        test_pixel_path();
        test_vertical();
        test_diag_pause();
        test_hits();
        test_pause_timer();
        test_reset_dying();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
